// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// State encoding, counter width helper and default parameter values.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      S_RST   = 3'd0,
      S_WAIT  = 3'd1,
      S_FILT  = 3'd2,
      S_READY = 3'd3,
      S_FAIL  = 3'd4
   } state_e;

   localparam int DEF_RST_CYCLES   = 16;
   localparam int DEF_LOCK_TIMEOUT = 50000;
   localparam int DEF_LOCK_FILTER  = 256;
   localparam int DEF_MAX_RETRIES  = 3;
   localparam int LOST_W           = 8;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int cw(input int n);
      return (n < 3) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchronizer for a single asynchronous status flag.
// Reset value is a parameter so it can be reused for active-low flags.
module sync_bit #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Reset and lock supervisor for the system PLL, clocked by refclk.
// Pulses pll_rst, qualifies lock, retries on timeout, re-sequences on loss.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_CYCLES   = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int LOCK_FILTER  = DEF_LOCK_FILTER,
   parameter int MAX_RETRIES  = DEF_MAX_RETRIES,
   localparam int RW          = $clog2(MAX_RETRIES + 1)
) (
   input  logic              refclk,
   input  logic              rst_n,
   input  logic              relock_req,
   input  logic              pll_locked,
   output logic              pll_rst,
   output logic              ready,
   output logic              fail,
   output logic [RW-1:0]     retry_cnt,
   output logic [LOST_W-1:0] lost_cnt
);

   localparam int RCW = cw(RST_CYCLES);
   localparam int TCW = cw(LOCK_TIMEOUT);
   localparam int FCW = cw(LOCK_FILTER);

   localparam logic [RCW-1:0] RC_LAST   = RCW'(RST_CYCLES - 1);
   localparam logic [TCW-1:0] TC_LAST   = TCW'(LOCK_TIMEOUT - 1);
   localparam logic [FCW-1:0] FC_LAST   = FCW'(LOCK_FILTER - 1);
   localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRIES);

   state_e              state, state_nx;
   logic [RCW-1:0]      rc, rc_nx;
   logic [TCW-1:0]      tc, tc_nx;
   logic [FCW-1:0]      fc, fc_nx;
   logic [RW-1:0]       retry_nx;
   logic [LOST_W-1:0]   lost_nx;
   logic                lk;
   logic                tmo;

   sync_bit #(.RST_VAL(1'b0)) u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (lk)
   );

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_RST;
         rc        <= '0;
         tc        <= '0;
         fc        <= '0;
         retry_cnt <= '0;
         lost_cnt  <= '0;
      end else begin
         state     <= state_nx;
         rc        <= rc_nx;
         tc        <= tc_nx;
         fc        <= fc_nx;
         retry_cnt <= retry_nx;
         lost_cnt  <= lost_nx;
      end
   end

   assign tmo = (tc == TC_LAST);

   always_comb begin
      state_nx = state;
      rc_nx    = rc;
      tc_nx    = tc;
      fc_nx    = fc;
      retry_nx = retry_cnt;
      lost_nx  = lost_cnt;
      if (relock_req) begin
         state_nx = S_RST;
         rc_nx    = '0;
         tc_nx    = '0;
         fc_nx    = '0;
         retry_nx = '0;
      end else begin
         unique case (state)
            S_RST: begin
               if (rc == RC_LAST) begin
                  state_nx = S_WAIT;
                  rc_nx    = '0;
                  tc_nx    = '0;
               end else begin
                  rc_nx = rc + 1'b1;
               end
            end
            S_WAIT, S_FILT: begin
               // Timeout is checked first so it beats a same-cycle lock.
               if (tmo) begin
                  fc_nx = '0;
                  if (retry_cnt < RETRY_MAX) begin
                     retry_nx = retry_cnt + 1'b1;
                     state_nx = S_RST;
                  end else begin
                     state_nx = S_FAIL;
                  end
               end else begin
                  tc_nx = tc + 1'b1;
                  if (!lk) begin
                     state_nx = S_WAIT;
                     fc_nx    = '0;
                  end else if (state == S_WAIT) begin
                     state_nx = S_FILT;
                     fc_nx    = '0;
                  end else if (fc == FC_LAST) begin
                     state_nx = S_READY;
                     fc_nx    = '0;
                     retry_nx = '0;
                  end else begin
                     fc_nx = fc + 1'b1;
                  end
               end
            end
            S_READY: begin
               if (!lk) begin
                  state_nx = S_RST;
                  rc_nx    = '0;
                  if (lost_cnt != '1) begin
                     lost_nx = lost_cnt + 1'b1;
                  end
               end
            end
            S_FAIL: begin
               state_nx = S_FAIL;
            end
            default: begin
               state_nx = S_RST;
            end
         endcase
      end
   end

   assign pll_rst = (state == S_RST) || (state == S_FAIL);
   assign ready   = (state == S_READY);
   assign fail    = (state == S_FAIL);

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed tables,
// multi-cycle corner sequences and random lock behaviour vs a model.
module tb_pll_lock_sequencer;

   localparam int RC = 4;
   localparam int LT = 100;
   localparam int LF = 8;
   localparam int MR = 2;
   localparam int RW = $clog2(MR + 1);

   logic          refclk = 1'b0;
   logic          rst_n = 1'b1;
   logic          relock_req = 1'b0;
   logic          pll_locked = 1'b0;
   logic          pll_rst, ready, fail;
   logic [RW-1:0] retry_cnt;
   logic [7:0]    lost_cnt;

   int total = 0;
   int bad   = 0;

   pll_lock_sequencer #(
      .RST_CYCLES   (RC),
      .LOCK_TIMEOUT (LT),
      .LOCK_FILTER  (LF),
      .MAX_RETRIES  (MR)
   ) dut (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .relock_req (relock_req),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .ready      (ready),
      .fail       (fail),
      .retry_cnt  (retry_cnt),
      .lost_cnt   (lost_cnt)
   );

   always #5 refclk = ~refclk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phases and elapsed-cycle tallies, lock seen 2 edges late.
   localparam int P_RST = 0, P_WAIT = 1, P_FILT = 2, P_READY = 3, P_FAIL = 4;
   int m_ph = P_RST, m_rc = 0, m_tc = 0, m_fc = 0, m_retry = 0, m_lost = 0;
   bit m_h1 = 1'b0, m_h2 = 1'b0, m_lk = 1'b0;

   task automatic m_step(input bit lk);
      if (relock_req) begin
         m_ph = P_RST; m_rc = 0; m_tc = 0; m_fc = 0; m_retry = 0;
         return;
      end
      case (m_ph)
         P_RST: begin
            m_rc++;
            if (m_rc == RC) begin m_ph = P_WAIT; m_tc = 0; m_rc = 0; end
         end
         P_WAIT, P_FILT: begin
            m_tc++;
            if (m_tc == LT) begin
               m_fc = 0;
               if (m_retry < MR) begin m_retry++; m_ph = P_RST; m_rc = 0; end
               else m_ph = P_FAIL;
            end else if (!lk) begin
               m_ph = P_WAIT; m_fc = 0;
            end else if (m_ph == P_WAIT) begin
               m_ph = P_FILT; m_fc = 0;
            end else begin
               m_fc++;
               if (m_fc == LF) begin m_ph = P_READY; m_retry = 0; m_fc = 0; end
            end
         end
         P_READY: begin
            if (!lk) begin
               if (m_lost < 255) m_lost++;
               m_ph = P_RST; m_rc = 0;
            end
         end
         default: ;
      endcase
   endtask

   always @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph = P_RST; m_rc = 0; m_tc = 0; m_fc = 0; m_retry = 0; m_lost = 0;
         m_h1 = 1'b0; m_h2 = 1'b0;
      end else begin
         m_lk = m_h2;
         m_h2 = m_h1;
         m_h1 = pll_locked;
         m_step(m_lk);
      end
   end

   always @(negedge refclk) begin
      chk("m_pll_rst", int'(pll_rst), int'(m_ph == P_RST || m_ph == P_FAIL));
      chk("m_ready", int'(ready), int'(m_ph == P_READY));
      chk("m_fail", int'(fail), int'(m_ph == P_FAIL));
      chk("m_retry", int'(retry_cnt), m_retry);
      chk("m_lost", int'(lost_cnt), m_lost);
   end

   // Asserts reset between clock edges and checks outputs before the next edge.
   task automatic do_reset();
      @(negedge refclk);
      #2;
      rst_n = 1'b0;
      pll_locked = 1'b0;
      relock_req = 1'b0;
      #1;
      chk("rst_pll_rst", int'(pll_rst), 1);
      chk("rst_ready", int'(ready), 0);
      chk("rst_fail", int'(fail), 0);
      chk("rst_retry", int'(retry_cnt), 0);
      chk("rst_lost", int'(lost_cnt), 0);
      @(negedge refclk);
      rst_n = 1'b1;
   endtask

   task automatic meas_high(output int len);
      len = 0;
      for (int k = 0; k < 60 && pll_rst; k++) begin
         len++;
         @(negedge refclk);
      end
   endtask

   task automatic meas_low(output int len);
      len = 0;
      for (int k = 0; k < 300 && !pll_rst; k++) begin
         len++;
         @(negedge refclk);
      end
   endtask

   task automatic wait_ready();
      int k;
      for (k = 0; k < 300 && !ready; k++) @(negedge refclk);
      if (!ready) chk("wait_ready_timeout", 0, 1);
   endtask

   typedef struct {
      int d;
      int hi;
      int lo;
      int exp_len;
      int exp_lat;
   } vec_t;

   vec_t tbl[5];

   initial begin
      #3000000;
      $display("FAIL watchdog: got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int len, lat, g, f;
      bit lv;
      // Latency after pll_rst falls: d + 2 sync + 1 (WAIT->FILT) + LF.
      tbl[0] = '{0, 0, 0, RC, 11};
      tbl[1] = '{3, 0, 0, RC, 14};
      tbl[2] = '{7, 0, 0, RC, 18};
      tbl[3] = '{3, 5, 2, RC, 21};
      // Glitch close to the end: timeout must still fire at cycle LT.
      tbl[4] = '{85, 5, 2, RC, 113};

      #1 rst_n = 1'b0;
      for (int t = 0; t < 5; t++) begin
         do_reset();
         meas_high(len);
         chk("t_rst_len", len, tbl[t].exp_len);
         lat = -1;
         for (int i = 0; i < 200; i++) begin
            if (i > 0) @(negedge refclk);
            if (ready) begin lat = i; break; end
            lv = (i >= tbl[t].d) &&
                 !(tbl[t].hi > 0 && i >= tbl[t].d + tbl[t].hi &&
                   i < tbl[t].d + tbl[t].hi + tbl[t].lo);
            pll_locked = lv;
         end
         chk("t_lat", lat, tbl[t].exp_lat);
         chk("t_retry", int'(retry_cnt), 0);
         chk("t_fail", int'(fail), 0);
      end

      // Retries then failure.
      do_reset();
      for (int p = 0; p < 3; p++) begin
         chk("f_retry", int'(retry_cnt), p);
         meas_high(len);
         chk("f_pulse", len, RC);
         meas_low(g);
         chk("f_gap", g, LT);
      end
      chk("f_fail", int'(fail), 1);
      repeat (10) @(negedge refclk);
      chk("f_stuck_rst", int'(pll_rst), 1);
      chk("f_stuck_fail", int'(fail), 1);
      relock_req = 1'b1;
      @(negedge refclk);
      relock_req = 1'b0;
      chk("f_clr_fail", int'(fail), 0);
      chk("f_clr_retry", int'(retry_cnt), 0);
      chk("f_clr_rst", int'(pll_rst), 1);

      // relock_req on the same edge as the final timeout.
      do_reset();
      for (int p = 0; p < 2; p++) begin
         meas_high(len);
         meas_low(g);
      end
      meas_high(len);
      chk("r_retry2", int'(retry_cnt), 2);
      repeat (LT - 1) @(negedge refclk);
      relock_req = 1'b1;
      @(negedge refclk);
      relock_req = 1'b0;
      chk("r_rst", int'(pll_rst), 1);
      chk("r_fail", int'(fail), 0);
      chk("r_retry", int'(retry_cnt), 0);
      meas_high(len);
      chk("r_pulse", len, RC);

      // Lock loss, repeated until lost_cnt saturates.
      do_reset();
      pll_locked = 1'b1;
      for (int n = 0; n < 300; n++) begin
         wait_ready();
         chk("l_retry", int'(retry_cnt), 0);
         pll_locked = 1'b0;
         f = 0;
         while (ready && f < 10) begin @(negedge refclk); f++; end
         if (n == 0) chk("l_fall_lat", f, 3);
         meas_high(len);
         if (n == 0) chk("l_pulse", len, RC);
         if (n == 0) chk("l_lost1", int'(lost_cnt), 1);
         pll_locked = 1'b1;
      end
      wait_ready();
      chk("l_lost_sat", int'(lost_cnt), 255);

      // Asynchronous reset from the middle of filtering.
      do_reset();
      pll_locked = 1'b1;
      wait_ready();
      pll_locked = 1'b0;
      repeat (3) @(negedge refclk);
      pll_locked = 1'b1;
      meas_high(len);
      repeat (5) @(negedge refclk);
      chk("m_lost_pre", int'(lost_cnt), 1);
      chk("m_ready_pre", int'(ready), 0);
      chk("m_pll_rst_pre", int'(pll_rst), 0);
      do_reset();

      // Random lock behaviour with occasional relock requests.
      begin
         int seg;
         seg = 0;
         for (int c = 0; c < 4000; c++) begin
            @(negedge refclk);
            if (seg == 0) begin
               pll_locked = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 9) == 0) seg = int'($urandom_range(100, 250));
               else seg = int'($urandom_range(1, 20));
            end else begin
               seg--;
            end
            relock_req = ($urandom_range(0, 63) == 0);
         end
         relock_req = 1'b0;
      end
      @(negedge refclk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
